fetch_pc_sequencer: RTL and testbench
=====================================

Name: fetch_pc_sequencer

Overview:
Owns the program counter feeding the instruction memory of the 5-stage MIPS pipeline. Each cycle it selects the next PC from sequential, branch/jump redirect, exception entry or ERET return, and honours hazard stalls. It range- and alignment-checks every fetch address against the IM window, then raises a fetch fault. It also gates fetch validity after reset and during fault recovery.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset
HANDLER_PC, 32'h0000_4180, exception handler entry
IM_BASE, 32'h0000_3000, first byte address of IM window
IM_WORDS, 4096, IM depth in words; last legal PC = IM_BASE + 4*IM_WORDS - 4 (0x6FFC)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hazard unit: hold PC and fetch
br_taken  in  1  D-stage branch taken this cycle
br_target  in  32  branch target
jmp  in  1  D-stage j/jal/jr/jalr
jmp_target  in  32  jump target
exc_req  in  1  CP0 exception/interrupt accepted (M stage)
eret  in  1  ERET committing
epc  in  32  return address from CP0
pc  out  32  current fetch address to IM
pc8  out  32  pc + 8 (link value)
if_valid  out  1  fetched word is a real instruction (else pipeline inserts NOP)
fetch_fault  out  1  current pc illegal (AdEL on fetch)
badvaddr  out  32  offending pc when fetch_fault=1, else 0
fetch_count  out  32  number of valid fetches accepted

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, state=BOOT, if_valid=0, fetch_fault=0, badvaddr=0, fetch_count=0.
- States: BOOT, RUN, FAULT.
- BOOT: lasts one cycle; pc held; if_valid=0; next state RUN unconditionally (exc_req ignored).
- RUN, next-PC priority, highest first:
  1. exc_req -> HANDLER_PC
  2. eret -> epc
  3. stall -> hold pc
  4. jmp -> jmp_target
  5. br_taken -> br_target
  6. otherwise pc+4
- exc_req and eret both high in the same cycle: exc_req wins.
- exc_req overrides stall. stall overrides redirects; D stage re-presents the redirect after the stall.
- jmp and br_taken both high is illegal by decode. If it occurs, jmp wins.
- Fault check is combinational on pc: fault when pc[1:0]!=0, pc<IM_BASE, or pc>last legal PC.
- RUN with fault (and not exc_req/eret): fetch_fault=1, badvaddr=pc, if_valid=0. Go to FAULT and hold pc.
- FAULT:
  - pc held, if_valid=0, fetch_fault stays 1 until leaving.
  - stall has no effect.
  - exc_req -> pc=HANDLER_PC, state RUN.
  - eret -> pc=epc, state RUN.
  - Nothing else leaves FAULT.
- if_valid = (state==RUN) & !stall & !fault.
- fetch_count increments by 1 on each clock edge where if_valid=1. It wraps 0xFFFF_FFFF -> 0 silently.
- pc8 = pc + 8, 32-bit wrap. pc+4 wraps mod 2^32; the resulting out-of-range address faults.
- Redirect targets are not checked at load time, only once they become pc.
- Reset asserted mid-operation returns to BOOT immediately, whatever the state.
- Latency: a redirect or exception asserted in cycle N appears on pc in cycle N+1.

Decomposition:
- Shared package/header: RESET_PC, HANDLER_PC, IM_BASE and the state encodings (BOOT=2'd0, RUN=2'd1, FAULT=2'd2). IM and CP0 use the same constants.
- One natural sub-module: fetch_addr_check (combinational range/alignment checker). It is reusable for the D-memory AdEL/AdES check.
- Next-PC mux and FSM stay in this module.

Test Plan:
- Reset release: pc=0x3000 and if_valid=0 for 1 cycle. Then pc 0x3000 -> 0x3004 -> 0x3008 with if_valid=1, and fetch_count=2 after two valid edges.
- stall=1 for 3 cycles at pc=0x3010 with br_taken=1, br_target=0x3100: pc holds 0x3010 and if_valid=0. On stall release with br_taken still 1, the next pc=0x3100.
- exc_req and stall together at pc=0x3020: next pc=0x4180. exc_req and eret together: pc=0x4180.
- jr to 0x3002: fetch_fault=1, badvaddr=0x3002, state FAULT, pc holds for 5 cycles despite stall toggling. Then exc_req -> pc=0x4180, fault cleared.
- Sequential run to 0x6FFC: next pc 0x7000 faults with badvaddr=0x7000. eret with epc=0x3040 -> pc=0x3040, RUN.
- Assert reset low mid-FAULT, asynchronously between edges: pc=0x3000, fetch_fault=0, fetch_count=0 immediately.

Source files
------------

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared fetch constants and FSM encoding for the IF stage.
// The IM and CP0 blocks import the same address constants.
package fetch_pc_sequencer_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam int unsigned IM_WORDS   = 4096;
  localparam logic [31:0] IM_LAST    = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational word-address legality check against a memory window.
// Reusable for the data-memory AdEL/AdES check.
module fetch_addr_check #(
  parameter logic [31:0] BASE  = 32'h0000_3000,
  parameter int unsigned WORDS = 4096
) (
  input  logic [31:0] addr_i,
  output logic        fault_o
);

  localparam logic [31:0] LAST = BASE + 32'(4 * WORDS) - 32'd4;

  logic misaligned;
  logic below;
  logic above;

  assign misaligned = |addr_i[1:0];
  assign below      = addr_i < BASE;
  assign above      = addr_i > LAST;
  assign fault_o    = misaligned | below | above;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Program counter owner for the IF stage: next-PC selection, fetch fault
// detection, fetch-valid gating and a count of accepted fetches.
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] pc8,
  output logic        if_valid,
  output logic        fetch_fault,
  output logic [31:0] badvaddr,
  output logic [31:0] fetch_count,
  output logic [1:0]  dbg_state
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic         addr_fault;

  fetch_addr_check #(
    .BASE  (IM_BASE),
    .WORDS (IM_WORDS)
  ) u_addr_check (
    .addr_i  (pc_q),
    .fault_o (addr_fault)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // exc_req and eret outrank both the fault check and stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (exc_req) begin
          pc_d = HANDLER_PC;
        end else if (eret) begin
          pc_d = epc;
        end else if (addr_fault) begin
          state_d = ST_FAULT;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (jmp) begin
          pc_d = jmp_target;
        end else if (br_taken) begin
          pc_d = br_target;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_FAULT: begin
        if (exc_req) begin
          pc_d    = HANDLER_PC;
          state_d = ST_RUN;
        end else if (eret) begin
          pc_d    = epc;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_PC;
      end
    endcase
  end

  always_comb begin
    if_valid    = (state_q == ST_RUN) && !stall && !addr_fault;
    fetch_fault = (state_q == ST_FAULT) ||
                  ((state_q == ST_RUN) && addr_fault && !exc_req && !eret);
    badvaddr    = fetch_fault ? pc_q : 32'd0;
  end

  assign count_d     = count_q + {31'd0, if_valid};
  assign pc          = pc_q;
  assign pc8         = pc_q + 32'd8;
  assign fetch_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_fetch_pc_sequencer;

  localparam logic [31:0] T_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] T_HANDLER  = 32'h0000_4180;
  localparam longint      T_LO       = 64'h3000;
  localparam longint      T_HI       = 64'h3000 + 4 * 4096 - 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_taken, jmp, exc_req, eret;
  logic [31:0] br_target, jmp_target, epc;
  logic [31:0] pc, pc8, badvaddr, fetch_count;
  logic        if_valid, fetch_fault;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  fetch_pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .exc_req     (exc_req),
    .eret        (eret),
    .epc         (epc),
    .pc          (pc),
    .pc8         (pc8),
    .if_valid    (if_valid),
    .fetch_fault (fetch_fault),
    .badvaddr    (badvaddr),
    .fetch_count (fetch_count),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall = 0; br_taken = 0; jmp = 0; exc_req = 0; eret = 0;
    br_target = 0; jmp_target = 0; epc = 0;
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_v,
                         input logic e_f, input logic [31:0] e_bad,
                         input logic [31:0] e_cnt, input logic [1:0] e_st);
    chk({tag, ".pc"},       pc,          e_pc);
    chk({tag, ".pc8"},      pc8,         e_pc + 32'd8);
    chk({tag, ".if_valid"}, {31'd0, if_valid},    {31'd0, e_v});
    chk({tag, ".fault"},    {31'd0, fetch_fault}, {31'd0, e_f});
    chk({tag, ".badvaddr"}, badvaddr,    e_bad);
    chk({tag, ".count"},    fetch_count, e_cnt);
    chk({tag, ".state"},    {30'd0, dbg_state},   {30'd0, e_st});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        st, br, jm, ex, er;
    logic [31:0] bt, jt, ep;
    logic [31:0] e_pc;
    logic        e_v, e_f;
    logic [31:0] e_bad, e_cnt;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic st, input logic br, input logic [31:0] bt,
                              input logic jm, input logic [31:0] jt, input logic ex,
                              input logic er, input logic [31:0] ep, input logic [31:0] e_pc,
                              input logic e_v, input logic e_f, input logic [31:0] e_bad,
                              input logic [31:0] e_cnt, input logic [1:0] e_st);
    vec_t v;
    v.st = st; v.br = br; v.bt = bt; v.jm = jm; v.jt = jt; v.ex = ex; v.er = er; v.ep = ep;
    v.e_pc = e_pc; v.e_v = e_v; v.e_f = e_f; v.e_bad = e_bad; v.e_cnt = e_cnt; v.e_st = e_st;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef enum int {M_BOOT, M_RUN, M_FAULT} mode_e;
  mode_e       m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  function automatic bit legal(input logic [31:0] a);
    longint v;
    v = longint'(a);
    return (v % 4 == 0) && (v >= T_LO) && (v <= T_HI);
  endfunction

  function automatic logic [31:0] rand_target();
    int r;
    r = $urandom_range(0, 7);
    if (r < 6) return 32'h3000 + 32'(4 * $urandom_range(0, 4095));
    if (r == 6) return 32'h3000 + 32'($urandom_range(0, 16383));
    return $urandom;
  endfunction

  task automatic model_cycle();
    logic        e_v, e_f;
    logic [31:0] e_bad;
    logic [1:0]  e_st;
    e_v   = (m_mode == M_RUN) && !stall && legal(m_pc);
    e_f   = (m_mode == M_FAULT) || ((m_mode == M_RUN) && !legal(m_pc) && !exc_req && !eret);
    e_bad = e_f ? m_pc : 32'd0;
    e_st  = (m_mode == M_BOOT) ? 2'd0 : (m_mode == M_RUN) ? 2'd1 : 2'd2;
    chk_all("rnd", m_pc, e_v, e_f, e_bad, m_cnt, e_st);
    if (e_v) m_cnt = m_cnt + 1;
    if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (exc_req) begin
      m_pc = T_HANDLER; m_mode = M_RUN;
    end else if (eret) begin
      m_pc = epc; m_mode = M_RUN;
    end else if (m_mode == M_FAULT || !legal(m_pc)) begin
      m_mode = M_FAULT;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (jmp) begin
      m_pc = jmp_target;
    end else if (br_taken) begin
      m_pc = br_target;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // ---------------- main ----------------
  initial begin
    vecs[0]  = mk(0,0,0,          0,0,          0,0,0,          32'h3000,0,0,0,0,0);
    vecs[1]  = mk(0,0,0,          0,0,          0,0,0,          32'h3000,1,0,0,0,1);
    vecs[2]  = mk(0,0,0,          0,0,          0,0,0,          32'h3004,1,0,0,1,1);
    vecs[3]  = mk(0,0,0,          0,0,          0,0,0,          32'h3008,1,0,0,2,1);
    vecs[4]  = mk(0,0,0,          0,0,          0,0,0,          32'h300C,1,0,0,3,1);
    vecs[5]  = mk(1,1,32'h3100,   0,0,          0,0,0,          32'h3010,0,0,0,4,1);
    vecs[6]  = mk(1,1,32'h3100,   0,0,          0,0,0,          32'h3010,0,0,0,4,1);
    vecs[7]  = mk(1,1,32'h3100,   0,0,          0,0,0,          32'h3010,0,0,0,4,1);
    vecs[8]  = mk(0,1,32'h3100,   0,0,          0,0,0,          32'h3010,1,0,0,4,1);
    vecs[9]  = mk(0,0,0,          1,32'h3020,   0,0,0,          32'h3100,1,0,0,5,1);
    vecs[10] = mk(1,0,0,          0,0,          1,0,0,          32'h3020,0,0,0,6,1);
    vecs[11] = mk(0,0,0,          0,0,          0,0,0,          32'h4180,1,0,0,6,1);
    vecs[12] = mk(0,0,0,          0,0,          1,1,32'h3040,   32'h4184,1,0,0,7,1);
    vecs[13] = mk(0,0,0,          1,32'h3002,   0,0,0,          32'h4180,1,0,0,8,1);
    vecs[14] = mk(1,0,0,          0,0,          0,0,0,          32'h3002,0,1,32'h3002,9,1);
    vecs[15] = mk(0,0,0,          0,0,          0,0,0,          32'h3002,0,1,32'h3002,9,2);
    vecs[16] = mk(1,0,0,          0,0,          0,0,0,          32'h3002,0,1,32'h3002,9,2);
    vecs[17] = mk(0,1,32'h3100,   0,0,          0,0,0,          32'h3002,0,1,32'h3002,9,2);
    vecs[18] = mk(1,0,0,          0,0,          0,0,0,          32'h3002,0,1,32'h3002,9,2);
    vecs[19] = mk(0,0,0,          0,0,          1,0,0,          32'h3002,0,1,32'h3002,9,2);
    vecs[20] = mk(0,0,0,          0,0,          0,0,0,          32'h4180,1,0,0,9,1);

    do_reset();
    foreach (vecs[i]) begin
      stall = vecs[i].st; br_taken = vecs[i].br; br_target = vecs[i].bt;
      jmp = vecs[i].jm; jmp_target = vecs[i].jt;
      exc_req = vecs[i].ex; eret = vecs[i].er; epc = vecs[i].ep;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_v, vecs[i].e_f,
              vecs[i].e_bad, vecs[i].e_cnt, vecs[i].e_st);
      tick();
    end

    // End of IM window: 0x6FFC is the last legal fetch, 0x7000 faults.
    clr(); jmp = 1; jmp_target = 32'h6FF8;
    tick(); clr(); #1;
    chk("win.pc6ff8", pc, 32'h6FF8);
    tick(); #1;
    chk("win.pc6ffc", pc, 32'h6FFC);
    chk("win.valid6ffc", {31'd0, if_valid}, 32'd1);
    chk("win.nofault6ffc", {31'd0, fetch_fault}, 32'd0);
    tick(); #1;
    chk("win.pc7000", pc, 32'h7000);
    chk("win.fault7000", {31'd0, fetch_fault}, 32'd1);
    chk("win.bad7000", badvaddr, 32'h7000);
    chk("win.valid7000", {31'd0, if_valid}, 32'd0);
    tick(); #1;
    chk("win.state_fault", {30'd0, dbg_state}, 32'd2);
    chk("win.hold7000", pc, 32'h7000);
    eret = 1; epc = 32'h3040;
    tick(); clr(); #1;
    chk("eret.pc", pc, 32'h3040);
    chk("eret.state", {30'd0, dbg_state}, 32'd1);
    chk("eret.fault", {31'd0, fetch_fault}, 32'd0);
    chk("eret.valid", {31'd0, if_valid}, 32'd1);

    // pc8 wraps modulo 2^32; the wrapped-region pc itself faults.
    jmp = 1; jmp_target = 32'hFFFF_FFFC;
    tick(); clr(); #1;
    chk("wrap.pc8", pc8, 32'h0000_0004);
    chk("wrap.fault", {31'd0, fetch_fault}, 32'd1);
    chk("wrap.bad", badvaddr, 32'hFFFF_FFFC);
    tick();

    // Asynchronous reset between edges while in FAULT.
    #2;
    reset = 1'b0;
    #1;
    chk("areset.pc", pc, T_RESET_PC);
    chk("areset.fault", {31'd0, fetch_fault}, 32'd0);
    chk("areset.count", fetch_count, 32'd0);
    chk("areset.state", {30'd0, dbg_state}, 32'd0);
    chk("areset.bad", badvaddr, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("boot.valid", {31'd0, if_valid}, 32'd0);
    tick(); #1;
    chk("boot.run_pc", pc, T_RESET_PC);
    chk("boot.run_valid", {31'd0, if_valid}, 32'd1);

    // Randomized run against the behavioural model.
    do_reset();
    m_mode = M_BOOT; m_pc = T_RESET_PC; m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      stall      = ($urandom_range(0, 3) == 0);
      jmp        = ($urandom_range(0, 7) == 0);
      br_taken   = ($urandom_range(0, 5) == 0);
      exc_req    = ($urandom_range(0, 19) == 0);
      eret       = ($urandom_range(0, 15) == 0);
      jmp_target = rand_target();
      br_target  = rand_target();
      epc        = rand_target();
      #1;
      model_cycle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
